// File: rtl/mpc_pkg.sv
// Shared MPC definitions: gate-driver state encoding and default timing constants.
package mpc_pkg;

  typedef enum logic [2:0] {
    DISABLED    = 3'd0,
    OFF         = 3'd1,
    DEAD_TO_ON  = 3'd2,
    ON          = 3'd3,
    DEAD_TO_OFF = 3'd4
  } mpc_state_e;

  localparam int unsigned MPC_DEAD_CYCLES    = 8;
  localparam int unsigned MPC_MIN_ON_CYCLES  = 64;
  localparam int unsigned MPC_MIN_OFF_CYCLES = 64;
  localparam int unsigned MPC_CNT_W          = 16;

  // Switch state the power stage is currently committed to (high side or heading there).
  function automatic logic state_applied(input mpc_state_e s);
    return (s == ON) || (s == DEAD_TO_ON);
  endfunction

endpackage

// File: rtl/mpc_dwell_timer.sv
// Dwell counter: clear, saturating increment, compare against a supplied threshold.
module mpc_dwell_timer
  import mpc_pkg::*;
#(
  parameter int unsigned CNT_W = MPC_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] thr_i,
  output logic             ge_o,
  output logic             eq_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: restart on clear, otherwise count up and hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign ge_o = (count_q >= thr_i);
  assign eq_o = (count_q == thr_i);

endmodule

// File: rtl/mpc_gate_driver.sv
// Complementary gate driver: latches MPC switch decisions and applies them with
// dead time and minimum on/off dwell between high-side and low-side conduction.
module mpc_gate_driver
  import mpc_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES    = MPC_DEAD_CYCLES,
  parameter int unsigned MIN_ON_CYCLES  = MPC_MIN_ON_CYCLES,
  parameter int unsigned MIN_OFF_CYCLES = MPC_MIN_OFF_CYCLES,
  parameter int unsigned CNT_W          = MPC_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_strobe,
  input  logic       i_switch_cmd,
  output logic       o_gate_hi,
  output logic       o_gate_lo,
  output logic [2:0] o_state,
  output logic       o_cmd_dropped
);

  localparam logic [CNT_W-1:0] THR_DEAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] THR_ON   = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] THR_OFF  = CNT_W'(MIN_OFF_CYCLES - 1);

  mpc_state_e       state_q;
  mpc_state_e       state_d;
  logic             pending_q;
  logic             gate_hi_q;
  logic             gate_lo_q;
  logic             dropped_q;
  logic [CNT_W-1:0] dwell_thr;
  logic             dwell_ge;
  logic             dwell_eq;
  logic             dwell_clear;

  // Dwell threshold for the state currently being timed.
  always_comb begin
    dwell_thr = THR_DEAD;
    case (state_q)
      OFF:     dwell_thr = THR_OFF;
      ON:      dwell_thr = THR_ON;
      default: dwell_thr = THR_DEAD;
    endcase
  end

  // Next-state logic; disable overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED:    if (i_enable) state_d = OFF;
      OFF:         if (pending_q && dwell_ge) state_d = DEAD_TO_ON;
      DEAD_TO_ON:  if (dwell_eq) state_d = ON;
      ON:          if (!pending_q && dwell_ge) state_d = DEAD_TO_OFF;
      DEAD_TO_OFF: if (dwell_eq) state_d = OFF;
      default:     state_d = DISABLED;
    endcase
    if (!i_enable) begin
      state_d = DISABLED;
    end
  end

  // Counter restarts on every state entry.
  assign dwell_clear = (state_d != state_q);

  mpc_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .clear_i (dwell_clear),
    .thr_i   (dwell_thr),
    .ge_o    (dwell_ge),
    .eq_o    (dwell_eq)
  );

  // FSM state, command latch and gates registered from the next state so they never overlap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= DISABLED;
      pending_q <= 1'b0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_hi_q <= (state_d == ON);
      gate_lo_q <= (state_d == OFF);
      dropped_q <= i_strobe && (pending_q != state_applied(state_q));
      if (i_strobe) begin
        pending_q <= i_switch_cmd;
      end
    end
  end

  assign o_gate_hi     = gate_hi_q;
  assign o_gate_lo     = gate_lo_q;
  assign o_state       = state_q;
  assign o_cmd_dropped = dropped_q;

endmodule

// File: tb/tb_mpc_gate_driver.sv
// Self-checking bench for mpc_gate_driver: directed vector table, async-reset
// sequence, then random strobes checked against a reference model and output monitors.
module tb_mpc_gate_driver;

  localparam int DEAD    = 8;
  localparam int MIN_ON  = 64;
  localparam int MIN_OFF = 64;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic       i_strobe;
  logic       i_switch_cmd;
  logic       o_gate_hi;
  logic       o_gate_lo;
  logic [2:0] o_state;
  logic       o_cmd_dropped;

  always #5 i_clk = ~i_clk;

  mpc_gate_driver #(
    .DEAD_CYCLES    (DEAD),
    .MIN_ON_CYCLES  (MIN_ON),
    .MIN_OFF_CYCLES (MIN_OFF),
    .CNT_W          (16)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_strobe      (i_strobe),
    .i_switch_cmd  (i_switch_cmd),
    .o_gate_hi     (o_gate_hi),
    .o_gate_lo     (o_gate_lo),
    .o_state       (o_state),
    .o_cmd_dropped (o_cmd_dropped)
  );

  // {state[2:0], hi, lo, dropped}
  typedef logic [5:0] obs_t;

  typedef struct {
    int   reps;
    logic en;
    logic stb;
    logic cmd;
    obs_t exp;
  } vec_t;

  localparam int NV = 30;
  vec_t vec [NV];

  obs_t sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Reference model state
  int m_st;
  int m_cnt;
  bit m_pend;

  function automatic obs_t mk(input int st, input bit hi, input bit lo, input bit drop);
    return {st[2:0], hi, lo, drop};
  endfunction

  function automatic obs_t observe();
    return {o_state, o_gate_hi, o_gate_lo, o_cmd_dropped};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; optionally queue an expectation for the result after the edge.
  task automatic cycle(input bit en, input bit stb, input bit cmd, input bit push, input obs_t e,
                       input string tag);
    obs_t got_exp;
    i_enable     = en;
    i_strobe     = stb;
    i_switch_cmd = cmd;
    if (push) sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb_q.size() > 0) begin
      got_exp = sb_q.pop_front();
      check(tag, observe(), got_exp);
    end
  endtask

  // Behavioural reference: advance one clock and return the expected outputs.
  function automatic obs_t model_step(input bit en, input bit stb, input bit cmd);
    int ns;
    bit applied;
    bit drop;
    applied = (m_st == 3) || (m_st == 2);
    drop    = stb && (m_pend != applied);
    ns      = m_st;
    if (m_st == 0 && en) ns = 1;
    if (m_st == 1 && m_pend && m_cnt >= MIN_OFF - 1) ns = 2;
    if (m_st == 2 && m_cnt == DEAD - 1) ns = 3;
    if (m_st == 3 && !m_pend && m_cnt >= MIN_ON - 1) ns = 4;
    if (m_st == 4 && m_cnt == DEAD - 1) ns = 1;
    if (!en) ns = 0;
    if (ns != m_st) m_cnt = 0;
    else if (m_cnt < 65535) m_cnt = m_cnt + 1;
    if (stb) m_pend = cmd;
    m_st = ns;
    return mk(ns, ns == 3, ns == 1, drop);
  endfunction

  // Output monitor: overlap never allowed; dead runs exactly DEAD; on/off runs at least the minimum.
  int mon_run  = 0;
  int mon_kind = -1;
  always @(negedge i_clk) begin
    int k;
    if (mon_en) begin
      check("overlap", {31'd0, o_gate_hi & o_gate_lo}, 32'd0);
      if (o_state == 3'd0 || i_reset) begin
        mon_kind = -1;
        mon_run  = 0;
      end else begin
        k = o_gate_hi ? 1 : (o_gate_lo ? 2 : 0);
        if (k == mon_kind) begin
          mon_run++;
        end else begin
          if (mon_kind == 0) check("dead_len", mon_run, DEAD);
          else if (mon_kind == 1) check("min_on", {31'd0, mon_run >= MIN_ON}, 32'd1);
          else if (mon_kind == 2) check("min_off", {31'd0, mon_run >= MIN_OFF}, 32'd1);
          mon_kind = k;
          mon_run  = 1;
        end
      end
    end
  end

  initial begin
    bit en;
    bit stb;
    bit cmd;
    obs_t e;

    // reps, en, stb, cmd, expected after last rep
    vec[0]  = '{1,  1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0)};
    vec[1]  = '{1,  1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};  // enable -> OFF
    vec[2]  = '{99, 1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};
    vec[3]  = '{1,  1'b1, 1'b1, 1'b1, mk(1, 0, 1, 0)};  // strobe on at edge t
    vec[4]  = '{1,  1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0)};  // t+1: lo falls
    vec[5]  = '{7,  1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0)};  // t+8: still dead
    vec[6]  = '{1,  1'b1, 1'b0, 1'b0, mk(3, 1, 0, 0)};  // t+9: hi rises
    vec[7]  = '{9,  1'b1, 1'b0, 1'b0, mk(3, 1, 0, 0)};
    vec[8]  = '{1,  1'b1, 1'b1, 1'b0, mk(3, 1, 0, 0)};  // off request 10 into ON
    vec[9]  = '{52, 1'b1, 1'b0, 1'b0, mk(3, 1, 0, 0)};
    vec[10] = '{1,  1'b1, 1'b0, 1'b0, mk(3, 1, 0, 0)};  // 64th ON cycle
    vec[11] = '{1,  1'b1, 1'b0, 1'b0, mk(4, 0, 0, 0)};
    vec[12] = '{7,  1'b1, 1'b0, 1'b0, mk(4, 0, 0, 0)};
    vec[13] = '{1,  1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};
    vec[14] = '{1,  1'b1, 1'b1, 1'b1, mk(1, 0, 1, 0)};  // cmd=1 before min-off
    vec[15] = '{4,  1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};
    vec[16] = '{1,  1'b1, 1'b1, 1'b0, mk(1, 0, 1, 1)};  // cmd=0 overwrites: drop
    vec[17] = '{1,  1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};
    vec[18] = '{70, 1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};  // no transition
    vec[19] = '{1,  1'b1, 1'b1, 1'b1, mk(1, 0, 1, 0)};
    vec[20] = '{1,  1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0)};
    vec[21] = '{3,  1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0)};
    vec[22] = '{1,  1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0)};  // disable in DEAD_TO_ON
    vec[23] = '{1,  1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};  // re-enable, counter restarts
    vec[24] = '{63, 1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0)};
    vec[25] = '{1,  1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0)};
    vec[26] = '{8,  1'b1, 1'b0, 1'b0, mk(3, 1, 0, 0)};
    vec[27] = '{70, 1'b1, 1'b0, 1'b0, mk(3, 1, 0, 0)};
    vec[28] = '{1,  1'b1, 1'b1, 1'b0, mk(3, 1, 0, 0)};  // strobe at dwell expiry uses old pending
    vec[29] = '{1,  1'b1, 1'b0, 1'b0, mk(4, 0, 0, 0)};

    i_reset      = 1'b1;
    i_enable     = 1'b0;
    i_strobe     = 1'b0;
    i_switch_cmd = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_state", observe(), mk(0, 0, 0, 0));
    i_reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      for (int r = 0; r < vec[i].reps; r++) begin
        cycle(vec[i].en, (r == 0) ? vec[i].stb : 1'b0, vec[i].cmd,
              r == vec[i].reps - 1, vec[i].exp, $sformatf("vec%0d", i));
      end
    end

    // Asynchronous reset in the middle of an ON interval
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, "seq");
    repeat (72) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, "seq");
    check("pre_reset_on", observe(), mk(3, 1, 0, 0));
    #2;
    i_reset = 1'b1;
    #1;
    check("async_reset", observe(), mk(0, 0, 0, 0));
    @(posedge i_clk);
    #1;
    check("reset_held", observe(), mk(0, 0, 0, 0));
    i_reset = 1'b0;

    // Random strobes against the model, with output monitors running
    m_st   = 0;
    m_cnt  = 0;
    m_pend = 1'b0;
    mon_en = 1'b1;
    en     = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (en && $urandom_range(0, 2999) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
      stb = ($urandom_range(0, 39) == 0);
      cmd = $urandom_range(0, 1) != 0;
      e   = model_step(en, stb, cmd);
      cycle(en, stb, cmd, 1'b1, e, "model");
    end
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
